// File: rtl/pong_io_pkg.sv
// pong_io_pkg: definitions shared by the pong I/O bridge files.
//   state_t        - bridge FSM states.
//   DEF_INPUT_ADDR - default mailbox address that receives the button word.
//   DEF_OBJ_BASE   - default address of the first game-object word.
//   NUM_OBJ        - number of game-object words in the snapshot.
//   BALL_X..PAD_R  - object indices. The word address is OBJ_BASE + index.
package pong_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_IN,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_RD_LAST,
    ST_COMMIT
  } state_t;

  localparam logic [15:0] DEF_INPUT_ADDR = 16'h00F0;
  localparam logic [15:0] DEF_OBJ_BASE   = 16'h00F4;

  localparam int NUM_OBJ = 4;
  localparam int BALL_X  = 0;
  localparam int BALL_Y  = 1;
  localparam int PAD_L   = 2;
  localparam int PAD_R   = 3;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk  - destination clock
//   srst - synchronous active-high reset; clears both stages
//   d    - asynchronous input vector (WIDTH bits)
//   q    - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pong_io_bridge.sv
// pong_io_bridge: a master on BRAM port B that exchanges data with the game
// software once per video frame.
// On each accepted frame_tick it writes the synchronized button word to
// INPUT_ADDR. It then reads the four object words at OBJ_BASE..OBJ_BASE+3 and
// publishes all four together as a snapshot for the renderer.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   frame_tick        - one-cycle pulse per frame
//   buttons[3:0]      - raw asynchronous buttons {r_dn, r_up, l_dn, l_up}
//   q_b               - BRAM port B read data (one cycle after address)
//   addr_b/data_b/we_b- BRAM port B address, write data, write enable
//   ball_x..paddle_r  - snapshot words. They change only together.
//   frame_valid       - one-cycle pulse in the cycle the snapshot updates
//   busy              - high while a frame transaction is in progress
//   overrun           - sticky: a frame_tick arrived while not idle
module pong_io_bridge
  import pong_io_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] INPUT_ADDR = ADDR_W'(DEF_INPUT_ADDR),
  parameter logic [ADDR_W-1:0] OBJ_BASE   = ADDR_W'(DEF_OBJ_BASE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [3:0]        buttons,
  input  logic [DATA_W-1:0] q_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  output logic [DATA_W-1:0] ball_x,
  output logic [DATA_W-1:0] ball_y,
  output logic [DATA_W-1:0] paddle_l,
  output logic [DATA_W-1:0] paddle_r,
  output logic              frame_valid,
  output logic              busy,
  output logic              overrun
);

  // Object addresses wrap modulo 2^ADDR_W because the sum is ADDR_W bits wide.
  localparam logic [ADDR_W-1:0] ADDR_BALL_X = OBJ_BASE + ADDR_W'(BALL_X);
  localparam logic [ADDR_W-1:0] ADDR_BALL_Y = OBJ_BASE + ADDR_W'(BALL_Y);
  localparam logic [ADDR_W-1:0] ADDR_PAD_L  = OBJ_BASE + ADDR_W'(PAD_L);
  localparam logic [ADDR_W-1:0] ADDR_PAD_R  = OBJ_BASE + ADDR_W'(PAD_R);

  logic [3:0] btn_sync;

  sync_2ff #(
    .WIDTH(4)
  ) u_btn_sync (
    .clk (clk),
    .srst(reset),
    .d   (buttons),
    .q   (btn_sync)
  );

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_b_reg;
  logic [DATA_W-1:0] data_b_reg;
  logic              we_b_reg;
  logic              frame_valid_reg;
  logic              busy_reg;
  logic              overrun_reg;
  logic [DATA_W-1:0] shadow_reg [NUM_OBJ];
  logic [DATA_W-1:0] snap_reg   [NUM_OBJ];

  // Every output is registered. The values assigned on an edge belong to the
  // state being entered. Because of this, addr_b leads the matching q_b by
  // one state: the word addressed in RDk arrives while the FSM is in RDk+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      addr_b_reg      <= '0;
      data_b_reg      <= '0;
      we_b_reg        <= 1'b0;
      frame_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_reg[i] <= '0;
        snap_reg[i]   <= '0;
      end
    end else begin
      we_b_reg        <= 1'b0;
      data_b_reg      <= '0;
      frame_valid_reg <= 1'b0;

      // A tick in any state other than IDLE is dropped, including a tick
      // during COMMIT.
      if (frame_tick && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (frame_tick) begin
            state_reg  <= ST_WR_IN;
            addr_b_reg <= INPUT_ADDR;
            data_b_reg <= DATA_W'(btn_sync);
            we_b_reg   <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        ST_WR_IN: begin
          state_reg  <= ST_RD0;
          addr_b_reg <= ADDR_BALL_X;
        end
        ST_RD0: begin
          state_reg  <= ST_RD1;
          addr_b_reg <= ADDR_BALL_Y;
        end
        ST_RD1: begin
          state_reg          <= ST_RD2;
          addr_b_reg         <= ADDR_PAD_L;
          shadow_reg[BALL_X] <= q_b;
        end
        ST_RD2: begin
          state_reg          <= ST_RD3;
          addr_b_reg         <= ADDR_PAD_R;
          shadow_reg[BALL_Y] <= q_b;
        end
        ST_RD3: begin
          state_reg         <= ST_RD_LAST;
          shadow_reg[PAD_L] <= q_b;
        end
        ST_RD_LAST: begin
          // The last word is forwarded straight from q_b. This lets all four
          // snapshot words change on the same edge that enters COMMIT.
          state_reg         <= ST_COMMIT;
          shadow_reg[PAD_R] <= q_b;
          snap_reg[BALL_X]  <= shadow_reg[BALL_X];
          snap_reg[BALL_Y]  <= shadow_reg[BALL_Y];
          snap_reg[PAD_L]   <= shadow_reg[PAD_L];
          snap_reg[PAD_R]   <= q_b;
          frame_valid_reg   <= 1'b1;
        end
        ST_COMMIT: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_b      = addr_b_reg;
  assign data_b      = data_b_reg;
  assign we_b        = we_b_reg;
  assign frame_valid = frame_valid_reg;
  assign busy        = busy_reg;
  assign overrun     = overrun_reg;
  assign ball_x      = snap_reg[BALL_X];
  assign ball_y      = snap_reg[BALL_Y];
  assign paddle_l    = snap_reg[PAD_L];
  assign paddle_r    = snap_reg[PAD_R];

endmodule
